// File: rtl/rv32_pkg.sv
// Shared types for the rv32cpu memory arbiter: arbiter state encoding, access sizes and
// requester ids.
package rv32_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccIf = 2'd1,
    StAccD  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RQ_IF = 1'b0;
  localparam logic RQ_D  = 1'b1;

endpackage

// File: rtl/rv32_wait_timer.sv
// Memory wait-state counter: counts enabled cycles and flags the cycle in which the
// MAX_WAIT-th consecutive wait would be reached.
module rv32_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == 8'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates the single rv32cpu memory port between instruction fetch and data access.
// Define RV32_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT D grants.
module rv32_mem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
`ifdef RV32_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_do,
  output logic [1:0]  m_size,
  output logic        m_wr,
  input  logic [31:0] m_di,
  input  logic        m_ready
);

  arb_state_e  state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_do_q, m_do_d;
  logic [1:0]  m_size_q, m_size_d;
  logic        m_wr_q, m_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_done_q, d_done_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic acc, slot, expired, force_if, rq_cur;

  assign acc    = (state_q != StIdle);
  // A completing access frees the port in the same cycle, giving back-to-back accepts.
  assign slot   = !acc || m_ready;
  assign if_gnt = slot && if_req && (force_if || !d_req);
  assign d_gnt  = slot && d_req && !if_gnt;
  assign rq_cur = (state_q == StAccD) ? RQ_D : RQ_IF;

  rv32_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (slot),
    .en      (acc && !m_ready),
    .expired (expired)
  );

`ifdef RV32_ARB_STARVE_GUARD_EN
  logic [7:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && if_req && (starve_q != 8'(STARVE_LIMIT))) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_if = (starve_q == 8'(STARVE_LIMIT));
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_do_d     = m_do_q;
    m_size_d   = m_size_q;
    m_wr_d     = m_wr_q;
    if_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_done_d   = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_err_d    = 1'b0;

    if (acc && (m_ready || expired)) begin
      if (rq_cur == RQ_D) begin
        d_done_d  = 1'b1;
        d_rdata_d = (m_ready && !m_wr_q) ? m_di : 32'h0;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = m_ready ? m_di : 32'h0;
      end
      d_err_d   = !m_ready;
      state_d   = StIdle;
      m_valid_d = 1'b0;
      m_wr_d    = 1'b0;
    end

    if (if_gnt) begin
      state_d   = StAccIf;
      m_valid_d = 1'b1;
      m_addr_d  = if_addr;
      m_do_d    = 32'h0;
      m_size_d  = SZ_WORD;
      m_wr_d    = 1'b0;
    end else if (d_gnt) begin
      state_d   = StAccD;
      m_valid_d = 1'b1;
      m_addr_d  = d_addr;
      m_do_d    = d_wdata;
      m_size_d  = d_size;
      m_wr_d    = d_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_do_q     <= '0;
      m_size_q   <= '0;
      m_wr_q     <= 1'b0;
      if_done_q  <= 1'b0;
      if_rdata_q <= '0;
      d_done_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_do_q     <= m_do_d;
      m_size_q   <= m_size_d;
      m_wr_q     <= m_wr_d;
      if_done_q  <= if_done_d;
      if_rdata_q <= if_rdata_d;
      d_done_q   <= d_done_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_do     = m_do_q;
  assign m_size   = m_size_q;
  assign m_wr     = m_wr_q;
  assign if_done  = if_done_q;
  assign if_rdata = if_rdata_q;
  assign d_done   = d_done_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: transaction-level model checked every cycle plus directed
// literal expectations. Honours RV32_ARB_STARVE_GUARD_EN when defined.
module tb_rv32_mem_arbiter;

  localparam int MaxWait = 15;
  localparam int StarveLimit = 4;
`ifdef RV32_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_wr, m_ready;
  logic [31:0] if_addr, d_addr, d_wdata, m_di;
  logic [1:0]  d_size;
  logic        if_gnt, if_done, d_gnt, d_done, d_err, m_valid, m_wr;
  logic [31:0] if_rdata, d_rdata, m_addr, m_do;
  logic [1:0]  m_size;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  rv32_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_do     (m_do),
    .m_size   (m_size),
    .m_wr     (m_wr),
    .m_di     (m_di),
    .m_ready  (m_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding access, abort after MaxWait unanswered cycles.
  bit          md_busy, md_cur_d, md_cur_wr;
  int          md_waited, md_starve;
  logic        e_m_valid, e_m_wr, e_if_done, e_d_done, e_d_err;
  logic [31:0] e_m_addr, e_m_do, e_if_rdata, e_d_rdata;
  logic [1:0]  e_m_size;

  always @(negedge clk) begin
    bit slot, gi, gd, force_if;
    if (rst) begin
      md_busy = 0; md_waited = 0; md_starve = 0;
      e_m_valid = 0; e_m_wr = 0; e_if_done = 0; e_d_done = 0; e_d_err = 0;
      e_m_addr = 0; e_m_do = 0; e_if_rdata = 0; e_d_rdata = 0; e_m_size = 0;
      check("rst_m_valid", {31'b0, m_valid}, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_do", m_do, 0);
      check("rst_m_size", {30'b0, m_size}, 0);
      check("rst_m_wr", {31'b0, m_wr}, 0);
      check("rst_dones", {29'b0, if_done, d_done, d_err}, 0);
      check("rst_rdata", if_rdata | d_rdata, 0);
    end else begin
      check("m_valid", {31'b0, m_valid}, {31'b0, e_m_valid});
      check("if_done", {31'b0, if_done}, {31'b0, e_if_done});
      check("d_done", {31'b0, d_done}, {31'b0, e_d_done});
      check("d_err", {31'b0, d_err}, {31'b0, e_d_err});
      if (e_m_valid) begin
        check("m_addr", m_addr, e_m_addr);
        check("m_do", m_do, e_m_do);
        check("m_size", {30'b0, m_size}, {30'b0, e_m_size});
        check("m_wr", {31'b0, m_wr}, {31'b0, e_m_wr});
      end
      if (e_if_done) check("if_rdata", if_rdata, e_if_rdata);
      if (e_d_done) check("d_rdata", d_rdata, e_d_rdata);

      slot = !md_busy || m_ready;
      force_if = Guard && (md_starve == StarveLimit);
      gi = slot && if_req && (force_if || !d_req);
      gd = slot && d_req && !gi;
      check("if_gnt", {31'b0, if_gnt}, {31'b0, gi});
      check("d_gnt", {31'b0, d_gnt}, {31'b0, gd});

      e_if_done = 0; e_d_done = 0; e_d_err = 0;
      if (md_busy && m_ready) begin
        if (md_cur_d) begin
          e_d_done = 1; e_d_rdata = md_cur_wr ? 32'h0 : m_di;
        end else begin
          e_if_done = 1; e_if_rdata = m_di;
        end
        md_busy = 0; e_m_valid = 0;
      end else if (md_busy) begin
        md_waited++;
        if (md_waited == MaxWait) begin
          if (md_cur_d) begin e_d_done = 1; e_d_rdata = 0; end
          else begin e_if_done = 1; e_if_rdata = 0; end
          e_d_err = 1; md_busy = 0; e_m_valid = 0;
        end
      end
      if (gi) begin
        md_busy = 1; md_cur_d = 0; md_cur_wr = 0; md_waited = 0; md_starve = 0;
        e_m_valid = 1; e_m_addr = if_addr; e_m_do = 0; e_m_size = 2'b10; e_m_wr = 0;
      end else if (gd) begin
        md_busy = 1; md_cur_d = 1; md_cur_wr = d_wr; md_waited = 0;
        if (if_req && md_starve < StarveLimit) md_starve++;
        e_m_valid = 1; e_m_addr = d_addr; e_m_do = d_wdata; e_m_size = d_size; e_m_wr = d_wr;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, nd;
    bit seen;
    rst = 1; if_req = 0; d_req = 0; d_wr = 0; m_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_di = 0; d_size = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_m_valid", {31'b0, m_valid}, 0);
    check("reset_m_addr", m_addr, 0);
    check("reset_done_err", {29'b0, if_done, d_done, d_err}, 0);

    // 1: zero-wait fetch
    cyc(); if_req = 1; if_addr = 32'h100; m_ready = 1; m_di = 32'h13;
    @(negedge clk); check("t1_if_gnt", {31'b0, if_gnt}, 1);
    cyc(); if_req = 0;
    @(negedge clk);
    check("t1_m_valid", {31'b0, m_valid}, 1);
    check("t1_m_addr", m_addr, 32'h100);
    check("t1_m_wr", {31'b0, m_wr}, 0);
    cyc();
    @(negedge clk);
    check("t1_if_done", {31'b0, if_done}, 1);
    check("t1_if_rdata", if_rdata, 32'h13);

    // 2: simultaneous requests, D wins, back-to-back
    cyc(); m_ready = 1; if_req = 1; if_addr = 32'h104;
    d_req = 1; d_wr = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_size = 2'b10; m_di = 32'h55;
    @(negedge clk);
    check("t2_d_gnt", {31'b0, d_gnt}, 1);
    check("t2_if_gnt_blocked", {31'b0, if_gnt}, 0);
    cyc(); d_req = 0; d_wr = 0;
    @(negedge clk);
    check("t2_m_wr", {31'b0, m_wr}, 1);
    check("t2_m_do", m_do, 32'hDEADBEEF);
    check("t2_if_gnt_in_ready", {31'b0, if_gnt}, 1);
    cyc(); if_req = 0; m_di = 32'h77;
    @(negedge clk);
    check("t2_m_valid_kept", {31'b0, m_valid}, 1);
    check("t2_m_addr_if", m_addr, 32'h104);
    check("t2_d_done", {31'b0, d_done}, 1);
    check("t2_store_rdata", d_rdata, 0);
    cyc(); m_ready = 0;
    @(negedge clk);
    check("t2_if_rdata", if_rdata, 32'h77);

    // 3: wait states
    cyc(); d_req = 1; d_addr = 32'h3000; d_size = 2'b01;
    @(negedge clk); check("t3_d_gnt", {31'b0, d_gnt}, 1);
    cyc(); d_req = 0; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin m_ready = 1; m_di = 32'hCAFE1234; end
      @(negedge clk);
      if (m_valid && m_addr == 32'h3000 && m_size == 2'b01) cnt++;
      cyc();
    end
    m_ready = 0;
    @(negedge clk);
    check("t3_stable_cycles", cnt, 4);
    check("t3_d_done", {31'b0, d_done}, 1);
    check("t3_d_rdata", d_rdata, 32'hCAFE1234);

    // 4: timeout
    cyc(); d_req = 1; d_addr = 32'h5000; d_size = 2'b10;
    @(negedge clk); check("t4_d_gnt", {31'b0, d_gnt}, 1);
    cyc(); d_req = 0; cnt = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_done) begin seen = 1; break; end
      if (m_valid) cnt++;
      cyc();
    end
    check("t4_done_seen", {31'b0, seen}, 1);
    check("t4_valid_cycles", cnt, MaxWait);
    check("t4_d_err", {31'b0, d_err}, 1);
    check("t4_d_rdata", d_rdata, 0);
    check("t4_m_valid_low", {31'b0, m_valid}, 0);
    cyc(); d_req = 1; d_addr = 32'h5004; m_ready = 1; m_di = 32'h1234;
    @(negedge clk); check("t4_regrant", {31'b0, d_gnt}, 1);
    cyc(); d_req = 0;
    cyc();
    @(negedge clk);
    check("t4_after_done", {30'b0, d_done, d_err}, 2'b10);
    check("t4_after_rdata", d_rdata, 32'h1234);

    // 5: reset mid-access
    cyc(); m_ready = 0; d_req = 1; d_addr = 32'h6000;
    @(negedge clk); check("t5_d_gnt", {31'b0, d_gnt}, 1);
    cyc(); d_req = 0;
    @(negedge clk); check("t5_m_valid", {31'b0, m_valid}, 1);
    cyc(); rst = 1;
    #1;
    check("t5_async_valid", {31'b0, m_valid}, 0);
    check("t5_async_addr", m_addr, 0);
    cyc(); rst = 0;
    @(negedge clk); check("t5_no_done", {31'b0, d_done}, 0);
    cyc(); if_req = 1; if_addr = 32'h200; m_ready = 1; m_di = 32'h99;
    @(negedge clk); check("t5_if_gnt", {31'b0, if_gnt}, 1);
    cyc(); if_req = 0;
    cyc();
    @(negedge clk);
    check("t5_if_done", {31'b0, if_done}, 1);
    check("t5_if_rdata", if_rdata, 32'h99);

    // 6: starvation guard
    cyc(); d_req = 1; d_wr = 0; d_addr = 32'h7000; if_req = 1; if_addr = 32'h300; m_ready = 1;
    nd = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_gnt) begin seen = 1; break; end
      if (d_gnt) nd++;
      cyc();
    end
`ifdef RV32_ARB_STARVE_GUARD_EN
    check("t6_if_forced", {31'b0, seen}, 1);
    check("t6_d_grants", nd, StarveLimit);
`else
    check("t6_if_starved", {31'b0, seen}, 0);
    check("t6_d_grants", nd, 12);
`endif
    cyc(); d_req = 0; if_req = 0;
    repeat (4) cyc();
    m_ready = 0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
